// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - shared types, scan-code constants and Set 2 key map
package ps2_kbd_pkg;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} kbd_state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;

  localparam logic [4:0] IDX_ENTER = 5'd26;
  localparam logic [4:0] IDX_BKSP  = 5'd27;
  localparam logic [4:0] IDX_SPACE = 5'd28;

  typedef struct packed {
    logic       mapped;
    logic [4:0] idx;
  } key_map_t;

  function automatic key_map_t scan_to_idx(input logic [7:0] code);
    key_map_t m;
    m.mapped = 1'b1;
    m.idx    = 5'd0;
    case (code)
      8'h1C: m.idx = 5'd0;
      8'h32: m.idx = 5'd1;
      8'h21: m.idx = 5'd2;
      8'h23: m.idx = 5'd3;
      8'h24: m.idx = 5'd4;
      8'h2B: m.idx = 5'd5;
      8'h34: m.idx = 5'd6;
      8'h33: m.idx = 5'd7;
      8'h43: m.idx = 5'd8;
      8'h3B: m.idx = 5'd9;
      8'h42: m.idx = 5'd10;
      8'h4B: m.idx = 5'd11;
      8'h3A: m.idx = 5'd12;
      8'h31: m.idx = 5'd13;
      8'h44: m.idx = 5'd14;
      8'h4D: m.idx = 5'd15;
      8'h15: m.idx = 5'd16;
      8'h2D: m.idx = 5'd17;
      8'h1B: m.idx = 5'd18;
      8'h2C: m.idx = 5'd19;
      8'h3C: m.idx = 5'd20;
      8'h2A: m.idx = 5'd21;
      8'h1D: m.idx = 5'd22;
      8'h22: m.idx = 5'd23;
      8'h35: m.idx = 5'd24;
      8'h1A: m.idx = 5'd25;
      8'h5A: m.idx = IDX_ENTER;
      8'h66: m.idx = IDX_BKSP;
      8'h29: m.idx = IDX_SPACE;
      default: m.mapped = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - decoded-key valid/ready handshake toward the rotor logic
interface ps2_key_decoder_if;
  logic       key_valid;
  logic       key_ready;
  logic [4:0] key_idx;

  modport master (output key_valid, output key_idx, input key_ready);
  modport slave  (input key_valid, input key_idx, output key_ready);
endinterface

// File: rtl/ps2_key_decoder_fifo.sv
// rtl/ps2_key_decoder_fifo.sv - synchronous decoded-key FIFO with overflow pulse
module kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO drops the push even when a pop frees a slot this same cycle.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push & full;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - Set 2 make/break parser with typematic suppression feeding a key FIFO
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_rdy,
  input  logic [7:0]                    key_out,
  ps2_key_decoder_if.master             kif,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  kbd_state_t state, state_nx;
  logic       key_rdy_q, byte_stb;
  logic [7:0] held_code, held_code_nx;
  logic       held_valid, held_valid_nx;
  logic       push_req, fifo_empty, key_valid;
  key_map_t   km;

  assign byte_stb = key_rdy & ~key_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_rdy_q  <= 1'b0;
      held_code  <= 8'h00;
      held_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      key_rdy_q  <= key_rdy;
      held_code  <= held_code_nx;
      held_valid <= held_valid_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    held_code_nx  = held_code;
    held_valid_nx = held_valid;
    push_req      = 1'b0;
    km            = scan_to_idx(key_out);
    if (byte_stb) begin
      case (state)
        IDLE: begin
          if (key_out == SC_BREAK)      state_nx = BRK;
          else if (key_out == SC_EXT)   state_nx = EXT;
          // Held-key repeats are typematic; only a fresh make code is pushed.
          else if (km.mapped && !(held_valid && held_code == key_out)) begin
            push_req      = 1'b1;
            held_code_nx  = key_out;
            held_valid_nx = 1'b1;
          end
        end
        BRK: begin
          state_nx = IDLE;
          if (held_valid && key_out == held_code) held_valid_nx = 1'b0;
        end
        EXT:     state_nx = (key_out == SC_BREAK) ? EXT_BRK : IDLE;
        EXT_BRK: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign key_valid     = ~fifo_empty;
  assign kif.key_valid = key_valid;

  kbd_fifo #(.DEPTH(FIFO_DEPTH), .DW(5)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (km.idx),
    .pop       (key_valid & kif.key_ready),
    .pop_data  (kif.key_idx),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (overflow)
  );
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 frame receiver.
- Consumes its byte strobe (key_rdy level plus key_out scan code, Set 2).
- Parses make/break/extended prefixes, suppresses typematic auto-repeat, and maps A–Z plus Enter/Backspace/Space to a 5-bit key index.
- Buffers decoded keys in a small FIFO with a valid/ready handshake to the Enigma rotor/stepping logic.

Parameters:
- FIFO_DEPTH, 4, number of decoded key entries buffered (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- key_rdy  in  1  receiver byte-ready level; may stay high for many cycles
- key_out  in  8  receiver scan code, valid while key_rdy high
- key_valid  out  1  FIFO head holds a decoded key
- key_ready  in  1  consumer accepts head when key_valid & key_ready
- key_idx  out  5  head entry: 0–25 = A–Z, 26 = ENTER, 27 = BACKSPACE, 28 = SPACE
- overflow  out  1  one-cycle pulse when a decoded key is dropped because the FIFO is full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy (debug/status)

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values:
  - key_valid=0, key_idx=0, overflow=0, fifo_count=0
  - FSM=IDLE, held_valid=0, key_rdy_q=0, FIFO pointers=0
- Byte strobe: byte_stb = key_rdy & ~key_rdy_q, with key_rdy_q registered every cycle. A key_rdy level held high yields exactly one byte. key_out is sampled in the byte_stb cycle.
- Mapping (Set 2 → idx):
  - 1C→0 A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A→25 Z
  - 5A→26, 66→27, 29→28
  - All other codes are unmapped (including AA, FA, FE, 00, FF, E1).
- FSM, advancing only on byte_stb:
  - IDLE:
    - F0 → BRK
    - E0 → EXT
    - mapped code: if held_valid && held_code==code, drop it (typematic repeat). Otherwise request a push, set held_code=code and held_valid=1. Stay in IDLE.
    - unmapped → ignore, stay in IDLE.
  - BRK: any byte → IDLE. If held_valid && byte==held_code, clear held_valid. A break of a different key leaves held state unchanged.
  - EXT: F0 → EXT_BRK; any other byte → IDLE. Extended keys are ignored entirely.
  - EXT_BRK: any byte → IDLE, no other effect.
- Multi-key rollover: a new make code replaces held_code. Re-pressing the previously held key after another key was pressed emits again.
- FIFO:
  - Push request and fifo_count==FIFO_DEPTH at cycle start: the entry is dropped, overflow pulses for exactly one cycle, and held state is still updated.
  - A push on a full FIFO is dropped even if a pop occurs in the same cycle.
  - Pop when key_valid & key_ready.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs:
  - key_valid = (count != 0); key_idx = mem[rd_ptr], both registered/derived from state.
  - Latency: byte_stb in cycle N into an empty FIFO gives key_valid=1 in cycle N+1.
  - key_idx is stable while key_valid & ~key_ready.
- Reset mid-sequence: a prefix in progress is discarded, the FIFO is flushed, and held state is cleared.

Decomposition:
- Package ps2_kbd_pkg:
  - FSM state enum {IDLE, BRK, EXT, EXT_BRK}
  - scan-code constants SC_BREAK=8'hF0, SC_EXT=8'hE0
  - key index constants IDX_ENTER=26, IDX_BKSP=27, IDX_SPACE=28
  - function scan_to_idx(input [7:0] code, output mapped bit + 5-bit idx), a case table
- Sub-module kbd_fifo:
  - parameterised synchronous FIFO: push/pop/full/empty/count plus the overflow pulse
  - instantiated once

Test Plan:
- Byte 1C with key_rdy held high 5 cycles, then F0, 1C → exactly one entry, key_idx=0. Pop with key_ready=1 → key_valid=0 next cycle.
- Typematic sequence 1C,1C,1C,1C,F0,1C, then 1C → two entries total, both idx=0.
- Sequence E0,75,E0,F0,75 (arrow), then 1A → single entry idx=25; arrow produces nothing.
- Interleaved keys 1C (A), 32 (B), F0 1C, F0 32, 1C (A) → entries 0,1,0.
- key_ready=0, FIFO_DEPTH=4, makes 1C,32,21,23,24 → count=4 with contents 0,1,2,3; overflow pulses once on 24. Then drain → 0,1,2,3 in order.
- Send F0, assert rst for 1 cycle, then send 1C → entry idx=0 (break prefix discarded), count=1. Unmapped bytes AA, FA produce no entry and no overflow.
